// File: rtl/forward_net.sv
// forward_net: multi-port operand bypass network for the integer pipeline.
// Resolves each read port against the in-flight producer stages, then a
// committed-write history buffer, then the regfile data.
// Ports:
//   clk, resetn            clock, async active-low reset
//   st_regwrite/dst/data   producer stage i (0 = youngest)
//   st_ready               stage i result valid (0 = load in flight)
//   wb_en/dst/data         regfile commit, recorded in history
//   rd_addr, rf_data       per-port read address and regfile data
//   rd_data, rd_fwd        resolved operand, served-by-bypass flag
//   stall_req, stall_cnt   load-use hold, saturating stalled-cycle count
module forward_net #(
   parameter int NUM_STAGES = 3,
   parameter int NUM_RD     = 2,
   parameter int XLEN       = 64,
   parameter int REG_AW     = 5,
   parameter int HIST_DEPTH = 2,
   parameter int CNT_W      = 32
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [NUM_STAGES-1:0]        st_regwrite,
   input  logic [NUM_STAGES*REG_AW-1:0] st_dst,
   input  logic [NUM_STAGES*XLEN-1:0]   st_data,
   input  logic [NUM_STAGES-1:0]        st_ready,
   input  logic                         wb_en,
   input  logic [REG_AW-1:0]            wb_dst,
   input  logic [XLEN-1:0]              wb_data,
   input  logic [NUM_RD*REG_AW-1:0]     rd_addr,
   input  logic [NUM_RD*XLEN-1:0]       rf_data,
   output logic [NUM_RD*XLEN-1:0]       rd_data,
   output logic [NUM_RD-1:0]            rd_fwd,
   output logic                         stall_req,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

   logic [HIST_DEPTH-1:0] hv;
   logic [REG_AW-1:0]     ha [HIST_DEPTH];
   logic [XLEN-1:0]       hd [HIST_DEPTH];
   logic [PW-1:0]         wptr;

   logic [NUM_RD-1:0]     dem;
   logic [REG_AW-1:0]     a;
   logic                  hit;
   logic [PW-1:0]         idx;

   // Circular history; x0 commits carry no state and are dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hv   <= '0;
         wptr <= '0;
         for (int k = 0; k < HIST_DEPTH; k++) begin
            ha[k] <= '0;
            hd[k] <= '0;
         end
      end else if (wb_en && wb_dst != '0) begin
         hv[wptr] <= 1'b1;
         ha[wptr] <= wb_dst;
         hd[wptr] <= wb_data;
         if (wptr == PW'(HIST_DEPTH - 1))
            wptr <= '0;
         else
            wptr <= wptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         stall_cnt <= '0;
      else if (stall_req && !(&stall_cnt))
         stall_cnt <= stall_cnt + 1'b1;
   end

   always_comb begin
      rd_data = '0;
      rd_fwd  = '0;
      dem     = '0;
      a       = '0;
      hit     = 1'b0;
      idx     = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         a   = rd_addr[j*REG_AW +: REG_AW];
         hit = 1'b0;
         rd_data[j*XLEN +: XLEN] = rf_data[j*XLEN +: XLEN];
         if (a == '0) begin
            rd_data[j*XLEN +: XLEN] = '0;
            hit = 1'b1;
         end
         // Youngest matching stage owns the value, ready or not.
         for (int i = 0; i < NUM_STAGES; i++) begin
            if (!hit && st_regwrite[i] &&
                st_dst[i*REG_AW +: REG_AW] == a) begin
               hit = 1'b1;
               rd_data[j*XLEN +: XLEN] = st_data[i*XLEN +: XLEN];
               rd_fwd[j] = 1'b1;
               dem[j]    = !st_ready[i];
            end
         end
         // Walk history newest-first, starting just behind wptr.
         for (int k = 1; k <= HIST_DEPTH; k++) begin
            idx = PW'((int'(wptr) + HIST_DEPTH - k) % HIST_DEPTH);
            if (!hit && hv[idx] && ha[idx] == a) begin
               hit = 1'b1;
               rd_data[j*XLEN +: XLEN] = hd[idx];
               rd_fwd[j] = 1'b1;
            end
         end
      end
      stall_req = |dem;
   end

endmodule

// File: tb/tb_forward_net.sv
// tb_forward_net: scoreboard bench for forward_net.
// Expectations are queued with each stimulus and popped on sampling.
module tb_forward_net;

   logic          clk = 1'b0;
   logic          resetn;
   logic [2:0]    st_regwrite;
   logic [14:0]   st_dst;
   logic [191:0]  st_data;
   logic [2:0]    st_ready;
   logic          wb_en;
   logic [4:0]    wb_dst;
   logic [63:0]   wb_data;
   logic [9:0]    rd_addr;
   logic [127:0]  rf_data;
   logic [127:0]  rd_data;
   logic [1:0]    rd_fwd;
   logic          stall_req;
   logic [31:0]   stall_cnt;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string        name;
      logic [127:0] data;
      logic [127:0] mask;
      logic [1:0]   fwd;
      logic         stall;
   } exp_t;

   exp_t sb[$];

   forward_net #(
      .NUM_STAGES(3), .NUM_RD(2), .XLEN(64),
      .REG_AW(5), .HIST_DEPTH(2), .CNT_W(32)
   ) dut (
      .clk(clk), .resetn(resetn),
      .st_regwrite(st_regwrite), .st_dst(st_dst),
      .st_data(st_data), .st_ready(st_ready),
      .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
      .rd_addr(rd_addr), .rf_data(rf_data),
      .rd_data(rd_data), .rd_fwd(rd_fwd),
      .stall_req(stall_req), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic clear_in();
      st_regwrite = '0;
      st_dst      = '0;
      st_data     = '0;
      st_ready    = '1;
      wb_en       = 1'b0;
      wb_dst      = '0;
      wb_data     = '0;
   endtask

   task automatic set_st(input int i, input logic we, input logic [4:0] d,
                         input logic [63:0] v, input logic r);
      st_regwrite[i]    = we;
      st_dst[i*5 +: 5]  = d;
      st_data[i*64 +: 64] = v;
      st_ready[i]       = r;
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic push(input string n, input logic [63:0] d0,
                       input logic [63:0] d1, input logic [1:0] f,
                       input logic s, input logic [1:0] care);
      exp_t x;
      x.name  = n;
      x.data  = {d1, d0};
      x.mask  = {{64{care[1]}}, {64{care[0]}}};
      x.fwd   = f;
      x.stall = s;
      sb.push_back(x);
   endtask

   task automatic test_reset();
      exp_t e;
      set_rd(5'd5, 5'd7);
      rf_data = {64'h22, 64'h11};
      push("reset_rd", 64'h11, 64'h22, 2'b00, 1'b0, 2'b11);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (((rd_data & e.mask) !== (e.data & e.mask)) ||
             rd_fwd !== e.fwd || stall_req !== e.stall) begin
            fails++;
            $display("FAIL %s: got data=%h fwd=%b stall=%b, want data=%h fwd=%b stall=%b",
                     e.name, rd_data, rd_fwd, stall_req, e.data, e.fwd, e.stall);
         end
      end
      tests++;
      if (stall_cnt !== 32'd0) begin
         fails++;
         $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
      end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_priority();
      exp_t e;
      for (int step = 0; step < 3; step++) begin
         @(negedge clk);
         if (step == 0) begin
            clear_in();
            set_st(0, 1'b1, 5'd5, 64'hA, 1'b1);
            set_st(2, 1'b1, 5'd5, 64'hC, 1'b1);
            set_rd(5'd5, 5'd7);
            push("prio_s0", 64'hA, 64'h22, 2'b01, 1'b0, 2'b11);
         end else if (step == 1) begin
            set_st(0, 1'b0, 5'd5, 64'hA, 1'b1);
            push("prio_s2", 64'hC, 64'h22, 2'b01, 1'b0, 2'b11);
         end else begin
            set_st(1, 1'b1, 5'd5, 64'hB, 1'b1);
            set_rd(5'd7, 5'd5);
            push("prio_s1_p1", 64'h11, 64'hB, 2'b10, 1'b0, 2'b11);
         end
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (((rd_data & e.mask) !== (e.data & e.mask)) ||
                rd_fwd !== e.fwd || stall_req !== e.stall) begin
               fails++;
               $display("FAIL %s: got data=%h fwd=%b stall=%b, want data=%h fwd=%b stall=%b",
                        e.name, rd_data, rd_fwd, stall_req, e.data, e.fwd, e.stall);
            end
         end
      end
   endtask

   task automatic test_load_use();
      exp_t e;
      @(negedge clk);
      clear_in();
      set_st(0, 1'b1, 5'd5, 64'hA, 1'b0);
      set_st(1, 1'b1, 5'd5, 64'hB, 1'b1);
      set_rd(5'd5, 5'd7);
      push("lu_stall", 64'h0, 64'h22, 2'b01, 1'b1, 2'b10);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (((rd_data & e.mask) !== (e.data & e.mask)) ||
             rd_fwd !== e.fwd || stall_req !== e.stall) begin
            fails++;
            $display("FAIL %s: got data=%h fwd=%b stall=%b, want data=%h fwd=%b stall=%b",
                     e.name, rd_data, rd_fwd, stall_req, e.data, e.fwd, e.stall);
         end
      end
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         tests++;
         if (stall_cnt !== 32'(k)) begin
            fails++;
            $display("FAIL lu_cnt%0d: got %0d want %0d", k, stall_cnt, k);
         end
      end
      @(negedge clk);
      st_ready[0] = 1'b1;
      push("lu_release", 64'hA, 64'h22, 2'b01, 1'b0, 2'b11);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (((rd_data & e.mask) !== (e.data & e.mask)) ||
             rd_fwd !== e.fwd || stall_req !== e.stall) begin
            fails++;
            $display("FAIL %s: got data=%h fwd=%b stall=%b, want data=%h fwd=%b stall=%b",
                     e.name, rd_data, rd_fwd, stall_req, e.data, e.fwd, e.stall);
         end
      end
      @(posedge clk);
      #1;
      tests++;
      if (stall_cnt !== 32'd3) begin
         fails++;
         $display("FAIL lu_cnt_hold: got %0d want 3", stall_cnt);
      end
   endtask

   task automatic test_x0();
      exp_t e;
      for (int step = 0; step < 4; step++) begin
         @(negedge clk);
         if (step == 0) begin
            clear_in();
            for (int i = 0; i < 3; i++)
               set_st(i, 1'b1, 5'd0, 64'hFF, 1'b0);
            set_rd(5'd0, 5'd0);
            push("x0_read", 64'h0, 64'h0, 2'b00, 1'b0, 2'b11);
         end else if (step == 1) begin
            clear_in();
            wb_en   = 1'b1;
            wb_dst  = 5'd8;
            wb_data = 64'h88;
            set_rd(5'd8, 5'd0);
            push("x0_wb_same", 64'h11, 64'h0, 2'b00, 1'b0, 2'b11);
         end else if (step == 2) begin
            wb_dst  = 5'd0;
            wb_data = 64'hEE;
            push("x0_hist_x8", 64'h88, 64'h0, 2'b01, 1'b0, 2'b11);
         end else begin
            wb_dst  = 5'd9;
            wb_data = 64'h99;
            @(negedge clk);
            wb_en = 1'b0;
            set_rd(5'd8, 5'd9);
            push("x0_not_hist", 64'h88, 64'h99, 2'b11, 1'b0, 2'b11);
         end
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (((rd_data & e.mask) !== (e.data & e.mask)) ||
                rd_fwd !== e.fwd || stall_req !== e.stall) begin
               fails++;
               $display("FAIL %s: got data=%h fwd=%b stall=%b, want data=%h fwd=%b stall=%b",
                        e.name, rd_data, rd_fwd, stall_req, e.data, e.fwd, e.stall);
            end
         end
      end
   endtask

   task automatic test_history();
      exp_t e;
      for (int step = 0; step < 5; step++) begin
         @(negedge clk);
         if (step == 0) begin
            wb_en   = 1'b1;
            wb_dst  = 5'd3;
            wb_data = 64'd1;
            set_rd(5'd3, 5'd4);
            push("hist_same_cyc", 64'h11, 64'h22, 2'b00, 1'b0, 2'b11);
         end else if (step == 1) begin
            wb_dst  = 5'd3;
            wb_data = 64'd2;
            push("hist_x3_1", 64'd1, 64'h22, 2'b01, 1'b0, 2'b11);
         end else if (step == 2) begin
            wb_dst  = 5'd4;
            wb_data = 64'd9;
            push("hist_x3_newest", 64'd2, 64'h22, 2'b01, 1'b0, 2'b11);
         end else if (step == 3) begin
            wb_en = 1'b0;
            push("hist_x3_x4", 64'd2, 64'd9, 2'b11, 1'b0, 2'b11);
         end else begin
            wb_en   = 1'b1;
            wb_dst  = 5'd6;
            wb_data = 64'd5;
            @(negedge clk);
            wb_en = 1'b0;
            push("hist_wrap", 64'h11, 64'd9, 2'b10, 1'b0, 2'b11);
         end
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (((rd_data & e.mask) !== (e.data & e.mask)) ||
                rd_fwd !== e.fwd || stall_req !== e.stall) begin
               fails++;
               $display("FAIL %s: got data=%h fwd=%b stall=%b, want data=%h fwd=%b stall=%b",
                        e.name, rd_data, rd_fwd, stall_req, e.data, e.fwd, e.stall);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      @(negedge clk);
      clear_in();
      set_st(0, 1'b1, 5'd5, 64'hA, 1'b0);
      set_rd(5'd4, 5'd5);
      push("ar_p1_stall", 64'd9, 64'h0, 2'b11, 1'b1, 2'b01);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (((rd_data & e.mask) !== (e.data & e.mask)) ||
             rd_fwd !== e.fwd || stall_req !== e.stall) begin
            fails++;
            $display("FAIL %s: got data=%h fwd=%b stall=%b, want data=%h fwd=%b stall=%b",
                     e.name, rd_data, rd_fwd, stall_req, e.data, e.fwd, e.stall);
         end
      end
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (stall_cnt !== 32'd7) begin
         fails++;
         $display("FAIL ar_cnt7: got %0d want 7", stall_cnt);
      end
      #2;
      resetn = 1'b0;
      push("ar_hist_clr", 64'h11, 64'h0, 2'b10, 1'b1, 2'b01);
      #1;
      tests++;
      if (stall_cnt !== 32'd0) begin
         fails++;
         $display("FAIL ar_cnt_clr: got %0d want 0", stall_cnt);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (((rd_data & e.mask) !== (e.data & e.mask)) ||
             rd_fwd !== e.fwd || stall_req !== e.stall) begin
            fails++;
            $display("FAIL %s: got data=%h fwd=%b stall=%b, want data=%h fwd=%b stall=%b",
                     e.name, rd_data, rd_fwd, stall_req, e.data, e.fwd, e.stall);
         end
      end
      @(posedge clk);
      #1;
      tests++;
      if (stall_cnt !== 32'd0) begin
         fails++;
         $display("FAIL ar_cnt_held: got %0d want 0", stall_cnt);
      end
      @(negedge clk);
      clear_in();
      resetn = 1'b1;
      set_rd(5'd4, 5'd6);
      push("ar_after", 64'h11, 64'h22, 2'b00, 1'b0, 2'b11);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (((rd_data & e.mask) !== (e.data & e.mask)) ||
             rd_fwd !== e.fwd || stall_req !== e.stall) begin
            fails++;
            $display("FAIL %s: got data=%h fwd=%b stall=%b, want data=%h fwd=%b stall=%b",
                     e.name, rd_data, rd_fwd, stall_req, e.data, e.fwd, e.stall);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      resetn  = 1'b0;
      rd_addr = '0;
      rf_data = '0;
      clear_in();
      test_reset();
      test_priority();
      test_load_use();
      test_x0();
      test_history();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
